axi_stream_extract_header: RTL and testbench

Receive-side counterpart of the header inserter. Takes an AXI Stream packet whose first beat carries a header, strips the leading byte_extract_cnt bytes, and presents them on a separate header channel. Re-aligns the remaining payload so every output beat is fully packed, MSB-first, until the final beat. Sits at the ingress of the packet pipeline, ahead of protocol parsing.

---
 rtl/axis_hdr_pkg.sv | 33 +++
 rtl/axis_byte_realign.sv | 28 ++
 rtl/axi_stream_extract_header.sv | 184 ++++++++++++++++++
 tb/tb_axi_stream_extract_header.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_hdr_pkg.sv
// Shared definitions for the AXI Stream header inserter/extractor pair.
// FSM state encoding plus byte-count to keep-mask helpers.
package axis_hdr_pkg;

  localparam int MAX_BYTES = 64;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    BODY,
    FLUSH
  } state_t;

  // n ones packed against the top of a w-bit keep field
  function automatic logic [MAX_BYTES-1:0] keep_msb(input int n, input int w);
    logic [MAX_BYTES-1:0] k;
    k = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (i < w && i >= w - n) k[i] = 1'b1;
    end
    return k;
  endfunction

  function automatic logic [MAX_BYTES-1:0] keep_lsb(input int n);
    logic [MAX_BYTES-1:0] k;
    k = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (i < n) k[i] = 1'b1;
    end
    return k;
  endfunction

endpackage

// File: rtl/axis_byte_realign.sv
// Combinational re-pack: residual bytes of the previous beat followed by the head of the new beat.
// Zero latency; no flow control of its own.
module axis_byte_realign #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic [DATA_WD-1:0]     res,
  input  logic [DATA_WD-1:0]     beat,
  input  logic [BYTE_CNT_WD-1:0] cnt,
  input  logic [BYTE_CNT_WD:0]   beat_bytes,
  output logic [DATA_WD-1:0]     cat_dat,
  output logic [DATA_WD-1:0]     next_res,
  output logic [BYTE_CNT_WD:0]   next_res_bytes
);
  int hdr_bits;
  int tail_bits;

  // Residual sits right-justified; with cnt=0 the beat shift is a full width and yields zero
  always_comb begin
    hdr_bits       = 8 * int'(cnt);
    tail_bits      = DATA_WD - hdr_bits;
    cat_dat        = (res << hdr_bits) | (beat >> tail_bits);
    next_res       = beat & ({DATA_WD{1'b1}} >> hdr_bits);
    next_res_bytes = (beat_bytes > {1'b0, cnt}) ? beat_bytes - {1'b0, cnt} : '0;
  end

endmodule

// File: rtl/axi_stream_extract_header.sv
// Strips a byte_extract_cnt-byte header off each AXI Stream packet and re-packs the payload MSB-first.
// Header 1 cycle after first beat; payload through a registered slice. SHORT_PKT_FLAG_EN adds short_pkt.
module axi_stream_extract_header
  import axis_hdr_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_extract,
  input  logic [BYTE_CNT_WD-1:0]  byte_extract_cnt,
  output logic                    ready_extract,
  output logic                    valid_header,
  output logic [DATA_WD-1:0]      data_header,
  output logic [DATA_BYTE_WD-1:0] keep_header,
  input  logic                    ready_header
`ifdef SHORT_PKT_FLAG_EN
  ,
  output logic                    short_pkt
`endif
);
  localparam int VW = BYTE_CNT_WD + 1;

  state_t                 state_q, state_d;
  logic [BYTE_CNT_WD-1:0] cnt_q;
  logic [VW-1:0]          cnt_ext, beat_bytes, hdr_bytes, res_bytes_q, nres_bytes;
  logic [DATA_WD-1:0]     res_q, nres_dat, cat_dat, realign_beat;
  logic                   cfg_fire, out_free;
  logic                   hdr_load, res_load, out_load, out_last_d;
  int                     keep_n;

  assign cnt_ext  = {1'b0, cnt_q};
  assign cfg_fire = valid_extract & ready_extract;
  assign out_free = ~valid_out | ready_out;

  // keep_in only qualifies the final beat; earlier beats count as full
  always_comb begin
    beat_bytes = VW'(DATA_BYTE_WD);
    if (last_in) begin
      beat_bytes = '0;
      for (int i = 0; i < DATA_BYTE_WD; i++) beat_bytes = beat_bytes + VW'(keep_in[i]);
    end
  end

  // A short packet's header is trimmed to the bytes that actually arrived
  assign hdr_bytes    = (last_in && beat_bytes < cnt_ext) ? beat_bytes : cnt_ext;
  assign realign_beat = (state_q == FLUSH) ? '0 : data_in;

  axis_byte_realign #(
    .DATA_WD      (DATA_WD),
    .DATA_BYTE_WD (DATA_BYTE_WD),
    .BYTE_CNT_WD  (BYTE_CNT_WD)
  ) u_realign (
    .res            (res_q),
    .beat           (realign_beat),
    .cnt            (cnt_q),
    .beat_bytes     (beat_bytes),
    .cat_dat        (cat_dat),
    .next_res       (nres_dat),
    .next_res_bytes (nres_bytes)
  );

  always_comb begin
    state_d       = state_q;
    ready_in      = 1'b0;
    ready_extract = 1'b0;
    hdr_load      = 1'b0;
    res_load      = 1'b0;
    out_load      = 1'b0;
    out_last_d    = 1'b0;
    keep_n        = DATA_BYTE_WD;
    case (state_q)
      IDLE: begin
        ready_extract = ~valid_header;
        if (valid_extract && !valid_header) state_d = FIRST;
      end
      FIRST: begin
        ready_in = ~valid_header;
        if (valid_in && !valid_header) begin
          hdr_load = 1'b1;
          res_load = 1'b1;
          if (!last_in)                state_d = BODY;
          else if (nres_bytes != '0)   state_d = FLUSH;
          else                         state_d = IDLE;
        end
      end
      BODY: begin
        ready_in = out_free;
        if (valid_in && out_free) begin
          res_load = 1'b1;
          out_load = 1'b1;
          if (last_in) begin
            if (beat_bytes > cnt_ext) begin
              state_d = FLUSH;
            end else begin
              out_last_d = 1'b1;
              keep_n     = DATA_BYTE_WD - int'(cnt_q) + int'(beat_bytes);
              state_d    = IDLE;
            end
          end
        end
      end
      FLUSH: begin
        if (out_free) begin
          out_load   = 1'b1;
          out_last_d = 1'b1;
          keep_n     = int'(res_bytes_q);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (cfg_fire) cnt_q <= byte_extract_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q       <= '0;
      res_bytes_q <= '0;
    end else if (res_load) begin
      res_q       <= nres_dat;
      res_bytes_q <= nres_bytes;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_header <= 1'b0;
      data_header  <= '0;
      keep_header  <= '0;
    end else if (hdr_load) begin
      valid_header <= 1'b1;
      data_header  <= data_in >> (8 * (DATA_BYTE_WD - int'(hdr_bytes)));
      keep_header  <= DATA_BYTE_WD'(keep_lsb(int'(hdr_bytes)));
    end else if (ready_header) begin
      valid_header <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
    end else if (out_load) begin
      valid_out <= 1'b1;
      data_out  <= cat_dat;
      keep_out  <= DATA_BYTE_WD'(keep_msb(keep_n, DATA_BYTE_WD));
      last_out  <= out_last_d;
    end else if (ready_out) begin
      valid_out <= 1'b0;
    end
  end

`ifdef SHORT_PKT_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) short_pkt <= 1'b0;
    else        short_pkt <= hdr_load & last_in & (beat_bytes <= cnt_ext);
  end
`endif

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Directed bench for axi_stream_extract_header at DATA_WD=32.
`timescale 1ns/1ps
module tb_axi_stream_extract_header;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
  } hdr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in, last_in, ready_in;
  logic [31:0] data_in;
  logic [3:0]  keep_in;
  logic        valid_out, last_out, ready_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        valid_extract, ready_extract;
  logic [1:0]  byte_extract_cnt;
  logic        valid_header, ready_header;
  logic [31:0] data_header;
  logic [3:0]  keep_header;
`ifdef SHORT_PKT_FLAG_EN
  logic        short_pkt;
  int          short_cnt = 0;
`endif

  int total = 0;
  int bad   = 0;

  beat_t out_q[$];
  hdr_t  hdr_q[$];

  always #5 clk = ~clk;

  axi_stream_extract_header dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .valid_in         (valid_in),
    .data_in          (data_in),
    .keep_in          (keep_in),
    .last_in          (last_in),
    .ready_in         (ready_in),
    .valid_out        (valid_out),
    .data_out         (data_out),
    .keep_out         (keep_out),
    .last_out         (last_out),
    .ready_out        (ready_out),
    .valid_extract    (valid_extract),
    .byte_extract_cnt (byte_extract_cnt),
    .ready_extract    (ready_extract),
    .valid_header     (valid_header),
    .data_header      (data_header),
    .keep_header      (keep_header),
    .ready_header     (ready_header)
`ifdef SHORT_PKT_FLAG_EN
    ,
    .short_pkt        (short_pkt)
`endif
  );

  // Inputs change just after posedge, so a handshake seen at negedge completes on the next posedge
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_out && ready_out)       out_q.push_back(beat_t'({data_out, keep_out, last_out}));
      if (valid_header && ready_header) hdr_q.push_back(hdr_t'({data_header, keep_header}));
`ifdef SHORT_PKT_FLAG_EN
      if (short_pkt) short_cnt = short_cnt + 1;
`endif
    end
  end

  task automatic send_cfg(input logic [1:0] c);
    int n;
    valid_extract = 1'b1;
    byte_extract_cnt = c;
    n = 0;
    @(negedge clk);
    while (!ready_extract && n < 200) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (ready_extract !== 1'b1) begin
      bad++;
      $display("FAIL cfg_handshake: ready_extract=%b want 1 within 200 cycles", ready_extract);
    end
    @(posedge clk); #1;
    valid_extract = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int n;
    valid_in = 1'b1;
    data_in  = d;
    keep_in  = k;
    last_in  = l;
    n = 0;
    @(negedge clk);
    while (!ready_in && n < 200) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (ready_in !== 1'b1) begin
      bad++;
      $display("FAIL beat_handshake: ready_in=%b want 1 within 200 cycles (data %h)", ready_in, d);
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    total++;
    if ({ready_in, valid_out, last_out, valid_header, ready_extract} !== 5'b00001) begin
      bad++;
      $display("FAIL reset_ctrl: rdy_in/vld_out/last/vld_hdr/rdy_ext=%b want 00001",
               {ready_in, valid_out, last_out, valid_header, ready_extract});
    end
    total++;
    if ({data_out, keep_out, data_header, keep_header} !== 72'h0) begin
      bad++;
      $display("FAIL reset_data: got %h %h %h %h want all zero", data_out, keep_out, data_header, keep_header);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({ready_in, valid_out, ready_extract} !== 3'b001) begin
      bad++;
      $display("FAIL reset_release: rdy_in/vld_out/rdy_ext=%b want 001", {ready_in, valid_out, ready_extract});
    end
    @(posedge clk); #1;
  endtask

  // cnt=2 three-beat packet; used standalone, under backpressure and after a mid-packet reset
  task automatic test_cnt2(input string tag);
    int ob, hb;
    beat_t exp[3];
    ob = out_q.size();
    hb = hdr_q.size();
    exp[0] = {32'hA3A4B1B2, 4'hF, 1'b0};
    exp[1] = {32'hB3B4C1C2, 4'hF, 1'b0};
    exp[2] = {32'hC3000000, 4'h8, 1'b1};
    send_cfg(2'd2);
    send_beat(32'hA1A2A3A4, 4'hF, 1'b0);
    send_beat(32'hB1B2B3B4, 4'hF, 1'b0);
    send_beat(32'hC1C2C300, 4'hE, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    total++;
    if (hdr_q.size() <= hb || hdr_q[hb] !== hdr_t'({32'h0000A1A2, 4'h3})) begin
      bad++;
      $display("FAIL %s header: got %h want %h", tag, (hdr_q.size() > hb) ? hdr_q[hb] : '0,
               hdr_t'({32'h0000A1A2, 4'h3}));
    end
    total++;
    if (out_q.size() - ob != 3) begin
      bad++;
      $display("FAIL %s beat_count: got %0d want 3", tag, out_q.size() - ob);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (out_q.size() <= ob + i || out_q[ob + i] !== exp[i]) begin
        bad++;
        $display("FAIL %s payload[%0d]: got %h want %h", tag, i,
                 (out_q.size() > ob + i) ? out_q[ob + i] : '0, exp[i]);
      end
    end
  endtask

  // Last beat carries one valid byte (55); two payload bytes remain valid and no flush beat follows
  task automatic test_cnt3;
    int ob, hb;
    ob = out_q.size();
    hb = hdr_q.size();
    send_cfg(2'd3);
    send_beat(32'h11223344, 4'hF, 1'b0);
    send_beat(32'h55667788, 4'h8, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (hdr_q.size() <= hb || hdr_q[hb] !== hdr_t'({32'h00112233, 4'h7})) begin
      bad++;
      $display("FAIL cnt3 header: got %h want %h", (hdr_q.size() > hb) ? hdr_q[hb] : '0,
               hdr_t'({32'h00112233, 4'h7}));
    end
    total++;
    if (out_q.size() - ob != 1) begin
      bad++;
      $display("FAIL cnt3 beat_count: got %0d want 1", out_q.size() - ob);
    end
    total++;
    if (out_q.size() <= ob || out_q[ob] !== beat_t'({32'h44556677, 4'hC, 1'b1})) begin
      bad++;
      $display("FAIL cnt3 payload: got %h want %h", (out_q.size() > ob) ? out_q[ob] : '0,
               beat_t'({32'h44556677, 4'hC, 1'b1}));
    end
  endtask

  task automatic test_cnt0;
    int ob, hb;
    beat_t exp[2];
    ob = out_q.size();
    hb = hdr_q.size();
    exp[0] = {32'h01020304, 4'hF, 1'b0};
    exp[1] = {32'h05060708, 4'hF, 1'b1};
    send_cfg(2'd0);
    send_beat(32'h01020304, 4'hF, 1'b0);
    send_beat(32'h05060708, 4'hF, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (hdr_q.size() <= hb || hdr_q[hb] !== hdr_t'({32'h0, 4'h0})) begin
      bad++;
      $display("FAIL cnt0 header: got %h want 0", (hdr_q.size() > hb) ? hdr_q[hb] : '1);
    end
    total++;
    if (out_q.size() - ob != 2) begin
      bad++;
      $display("FAIL cnt0 beat_count: got %0d want 2", out_q.size() - ob);
    end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (out_q.size() <= ob + i || out_q[ob + i] !== exp[i]) begin
        bad++;
        $display("FAIL cnt0 payload[%0d]: got %h want %h", i,
                 (out_q.size() > ob + i) ? out_q[ob + i] : '0, exp[i]);
      end
    end
  endtask

  task automatic test_short;
    int ob, hb;
`ifdef SHORT_PKT_FLAG_EN
    int sb;
    sb = short_cnt;
`endif
    ob = out_q.size();
    hb = hdr_q.size();
    send_cfg(2'd3);
    send_beat(32'hAABB0000, 4'hC, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (hdr_q.size() <= hb || hdr_q[hb] !== hdr_t'({32'h0000AABB, 4'h3})) begin
      bad++;
      $display("FAIL short header: got %h want %h", (hdr_q.size() > hb) ? hdr_q[hb] : '0,
               hdr_t'({32'h0000AABB, 4'h3}));
    end
    total++;
    if (out_q.size() != ob) begin
      bad++;
      $display("FAIL short no_payload: got %0d beats want 0", out_q.size() - ob);
    end
`ifdef SHORT_PKT_FLAG_EN
    total++;
    if (short_cnt - sb != 1) begin
      bad++;
      $display("FAIL short_pkt pulses: got %0d want 1", short_cnt - sb);
    end
`endif
  endtask

  task automatic test_backpressure;
    int ob, hb;
    logic prev_st;
    beat_t prev_b;
    ob = out_q.size();
    hb = hdr_q.size();
    ready_header = 1'b0;
    send_cfg(2'd1);
    send_beat(32'h11223344, 4'hF, 1'b1);
    repeat (3) @(negedge clk);
    total++;
    if ({valid_header, ready_extract} !== 2'b10) begin
      bad++;
      $display("FAIL bp hdr_blocks_cfg: vld_hdr/rdy_ext=%b want 10", {valid_header, ready_extract});
    end
    @(posedge clk); #1;
    ready_header = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({valid_header, ready_extract} !== 2'b01) begin
      bad++;
      $display("FAIL bp hdr_release: vld_hdr/rdy_ext=%b want 01", {valid_header, ready_extract});
    end
    @(posedge clk); #1;
    total++;
    if (hdr_q.size() <= hb || hdr_q[hb] !== hdr_t'({32'h00000011, 4'h1})) begin
      bad++;
      $display("FAIL bp header: got %h want %h", (hdr_q.size() > hb) ? hdr_q[hb] : '0,
               hdr_t'({32'h00000011, 4'h1}));
    end
    total++;
    if (out_q.size() - ob != 1 || out_q[ob] !== beat_t'({32'h22334400, 4'hE, 1'b1})) begin
      bad++;
      $display("FAIL bp flush_beat: count %0d first %h want %h", out_q.size() - ob,
               (out_q.size() > ob) ? out_q[ob] : '0, beat_t'({32'h22334400, 4'hE, 1'b1}));
    end
    prev_st = 1'b0;
    prev_b  = '0;
    fork
      test_cnt2("bp_toggle");
      begin
        repeat (60) begin
          @(posedge clk); #1;
          ready_out = ~ready_out;
        end
        ready_out = 1'b1;
      end
      begin
        repeat (60) begin
          @(negedge clk);
          if (prev_st) begin
            total++;
            if (valid_out !== 1'b1 || beat_t'({data_out, keep_out, last_out}) !== prev_b) begin
              bad++;
              $display("FAIL bp stall_hold: vld=%b beat %h want 1 %h", valid_out,
                       beat_t'({data_out, keep_out, last_out}), prev_b);
            end
          end
          prev_st = valid_out && !ready_out;
          prev_b  = {data_out, keep_out, last_out};
        end
      end
    join
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    ready_out = 1'b0;
    send_cfg(2'd2);
    send_beat(32'hDEADBEEF, 4'hF, 1'b0);
    send_beat(32'h12345678, 4'hF, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({valid_out, valid_header, ready_in, last_out, ready_extract} !== 5'b00001) begin
      bad++;
      $display("FAIL mid_reset async: vld_out/vld_hdr/rdy_in/last/rdy_ext=%b want 00001",
               {valid_out, valid_header, ready_in, last_out, ready_extract});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    ready_out = 1'b1;
    @(posedge clk); #1;
    test_cnt2("after_reset");
  endtask

  initial begin
    rst_n = 1'b1;
    valid_in = 1'b0;
    data_in = '0;
    keep_in = '0;
    last_in = 1'b0;
    ready_out = 1'b1;
    valid_extract = 1'b0;
    byte_extract_cnt = '0;
    ready_header = 1'b1;
    test_reset;
    test_cnt2("basic");
    test_cnt3;
    test_cnt0;
    test_short;
    test_backpressure;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
